// File: rtl/ahb_pkg.sv
// Shared AHB codes, state encoding and bus-response helper for the AHB memory slave.
package ahb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned BE_W   = 8;

    localparam logic [2:0] HSIZE_MAX = 3'd3;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_BUSY = 5'b00010,
        ST_DONE = 5'b00100,
        ST_ERR1 = 5'b01000,
        ST_ERR2 = 5'b10000
    } state_e;

    // {hreadyout, hresp} presented while the slave sits in state s
    function automatic logic [2:0] bus_resp(input state_e s);
        case (s)
            ST_BUSY: return {1'b0, HRESP_OKAY};
            ST_ERR1: return {1'b0, HRESP_ERROR};
            ST_ERR2: return {1'b1, HRESP_ERROR};
            default: return {1'b1, HRESP_OKAY};
        endcase
    endfunction

endpackage

// File: rtl/ahb_be_decode.sv
// Byte-lane enables and alignment check for one AHB beat on a 64-bit bus.
module ahb_be_decode
    import ahb_pkg::*;
(
    input  logic [2:0]      hsize,
    input  logic [2:0]      addr_lo,
    output logic [BE_W-1:0] be,
    output logic            misalign
);

    always_comb begin
        be       = '0;
        misalign = 1'b0;
        case (hsize)
            3'd0: be = 8'h01 << addr_lo;
            3'd1: begin
                be       = 8'h03 << addr_lo;
                misalign = addr_lo[0];
            end
            3'd2: begin
                be       = 8'h0F << addr_lo;
                misalign = |addr_lo[1:0];
            end
            3'd3: begin
                be       = 8'hFF;
                misalign = |addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB slave bridging single beats to a req/ack memory back-end, with
// decode errors, two-cycle ERROR responses and a back-end timeout guard.
module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] ADDR_SIZE = 32'h0001_0000,
    parameter int unsigned       TIMEOUT   = 16
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic [1:0]        hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  offset;
    logic [BE_W-1:0]    be;
    logic               misalign;
    logic               accept;
    logic               bad;
    logic               timeout_hit;
    logic               unused_ok;

    // Every beat is handled as a single, so the burst type carries no information here.
    assign unused_ok = ^hburst;

    assign mem_wdata = hwdata;

    ahb_be_decode u_be_decode (
        .hsize    (hsize),
        .addr_lo  (haddr[2:0]),
        .be       (be),
        .misalign (misalign)
    );

    // Wrapping subtraction keeps the window check correct even near the top of the map.
    assign offset      = haddr - BASE_ADDR;
    assign accept      = hsel && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    assign bad         = (offset >= ADDR_SIZE) || (hsize > HSIZE_MAX) || misalign;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
            hrdata    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    // Error beats ack; ack beats the timeout landing in the same cycle
                    if (mem_err || (!mem_ack && timeout_hit)) begin
                        state                <= ST_ERR1;
                        {hreadyout, hresp}   <= bus_resp(ST_ERR1);
                        mem_req              <= 1'b0;
                    end else if (mem_ack) begin
                        state                <= ST_DONE;
                        {hreadyout, hresp}   <= bus_resp(ST_DONE);
                        mem_req              <= 1'b0;
                        if (!mem_we) begin
                            hrdata <= mem_rdata;
                        end
                    end
                end
                ST_ERR1: begin
                    state              <= ST_ERR2;
                    {hreadyout, hresp} <= bus_resp(ST_ERR2);
                end
                // IDLE, DONE and ERR2 all complete a data phase and may take a new address
                default: begin
                    if (accept && bad) begin
                        state              <= ST_ERR1;
                        {hreadyout, hresp} <= bus_resp(ST_ERR1);
                    end else if (accept) begin
                        state              <= ST_BUSY;
                        {hreadyout, hresp} <= bus_resp(ST_BUSY);
                        mem_req            <= 1'b1;
                        mem_we             <= hwrite;
                        mem_addr           <= {haddr[ADDR_W-1:3], 3'b000};
                        mem_be             <= be;
                        cnt                <= '0;
                    end else begin
                        state              <= ST_IDLE;
                        {hreadyout, hresp} <= bus_resp(ST_IDLE);
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/ahb_mem_slave.md
Name: ahb_mem_slave

Overview:
- AHB responder (slave) side of the bus that the AXI-to-AHB bridge drives as initiator.
- Decodes single NONSEQ/SEQ transfers from a 64-bit AHB bus, inserts wait states and forwards each transfer to a simple req/ack memory or register back-end.
- Returns OKAY or two-cycle ERROR responses, with a back-end timeout guard.
- Sits between the AHB fabric and on-chip SRAM or CSR banks.

Parameters:
BASE_ADDR, 32'h0000_0000, first byte address claimed by this slave
ADDR_SIZE, 32'h0001_0000, size of claimed window in bytes (power of two)
TIMEOUT, 16, max cycles waiting for mem_ack/mem_err before forced ERROR; 0 disables

Ports:
hclk  in  1  bus clock, all logic on rising edge
hreset  in  1  synchronous active-high reset
hsel  in  1  slave select from decoder
haddr  in  32  address-phase address
htrans  in  2  IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
hwrite  in  1  1 write, 0 read
hsize  in  3  transfer size, 0..3 legal
hburst  in  3  ignored; every beat is treated as a single
hwdata  in  64  write data, valid in data phase
hready  in  1  bus-level ready (address phase is sampled only when high)
hreadyout  out  1  slave ready
hresp  out  2  OKAY=00, ERROR=01
hrdata  out  64  read data
mem_req  out  1  back-end request, held until ack/err/timeout
mem_we  out  1  1 write
mem_addr  out  32  {haddr[31:3],3'b0}
mem_be  out  8  byte enables
mem_wdata  out  64  equals hwdata (combinational pass-through)
mem_ack  in  1  back-end completion
mem_rdata  in  64  read data, valid with mem_ack
mem_err  in  1  back-end error, valid in place of or together with mem_ack

Behaviour:
- Reset (synchronous, hreset=1 at a rising edge):
  - state=IDLE, hreadyout=1, hresp=00, hrdata=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_be=0, timeout counter=0.
  - Reset mid-transfer drops mem_req immediately; any late ack is ignored.
- Accept condition (rising edge): hsel & hready & htrans[1]. hready here is the bus-level input.
  - On accept, the slave registers haddr, hwrite and hsize.
  - htrans IDLE/BUSY, or hsel=0, gives a zero-wait OKAY with no back-end activity.
- Decode error on accept goes to ERR1 with no mem_req. A decode error is any of:
  - haddr outside [BASE_ADDR, BASE_ADDR+ADDR_SIZE)
  - hsize>3
  - misalignment (size1 with addr[0]≠0, size2 with addr[1:0]≠0, size3 with addr[2:0]≠0)
- mem_be by size:
  - size0: 1<<addr[2:0]
  - size1: 8'h03<<addr[2:0]
  - size2: 8'h0F<<addr[2:0]
  - size3: 8'hFF
- States:
  - IDLE: hreadyout=1, hresp=00. Good accept goes to BUSY with mem_req, mem_we, mem_addr and mem_be registered.
  - BUSY: hreadyout=0, hresp=00, mem_req=1, counter increments.
    - mem_err goes to ERR1 (mem_err has priority over mem_ack in the same cycle).
    - mem_ack goes to DONE; on a read, hrdata<=mem_rdata.
    - counter==TIMEOUT-1 with no ack goes to ERR1 (ack in that same cycle wins).
    - mem_req clears on leaving BUSY.
  - DONE: hreadyout=1, hresp=00; this cycle completes the data phase.
    - A good accept in this cycle goes to BUSY (back-to-back pipelining).
    - A bad accept goes to ERR1; no accept goes to IDLE.
  - ERR1: hreadyout=0, hresp=01, then goes to ERR2.
  - ERR2: hreadyout=1, hresp=01. An accept here is honoured (BUSY or ERR1); otherwise goes to IDLE.
- Latency: minimum data phase is 2 cycles (first cycle back-end ack, then DONE). The master holds hwdata stable while hreadyout=0.
- hrdata holds its last value outside read completions. Writes never update hrdata.
- Counter resets on every entry to BUSY.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS codes and HRESP codes
  - HSIZE max (3)
  - state encoding (IDLE, BUSY, DONE, ERR1, ERR2), one-hot 5-bit
- One sub-module: ahb_be_decode (combinational). It takes hsize and haddr[2:0] and produces mem_be[7:0] and misalign.
- The top holds the FSM, the address-range check and the timeout counter.

Test Plan:
- Write hsize=3, haddr=BASE+0x10, hwdata=64'hDEAD_BEEF_0123_4567, mem_ack after 3 cycles -> mem_req high exactly 3 cycles, mem_be=8'hFF, mem_addr=BASE+0x10, hreadyout low 3 cycles then high one cycle, hresp=00.
- Read hsize=1, haddr=BASE+0x6, mem_rdata=64'h1122_3344_5566_7788 with ack in first BUSY cycle -> mem_be=8'hC0, hrdata=64'h1122_3344_5566_7788 in the DONE cycle, total data phase 2 cycles.
- Address BASE+ADDR_SIZE, or hsize=2 at addr ending 0x2 -> no mem_req; hreadyout=0/hresp=01 then hreadyout=1/hresp=01.
- Back end silent with TIMEOUT=16 -> mem_req high 16 cycles then drops, two-cycle ERROR; a later transfer completes with OKAY.
- Back-to-back NONSEQ write then read, second address presented during the DONE cycle -> second mem_req asserts the cycle after DONE with no IDLE gap; mem_ack and mem_err together -> ERROR.
- hreset asserted while in BUSY -> next cycle mem_req=0, hreadyout=1, hresp=00, hrdata=0; a mem_ack arriving after reset causes no response.
